// File: rtl/uart_flow_ctrl.sv
// rtl/uart_flow_ctrl.sv - buffered full-duplex UART with RTS/CTS flow control
// Valid/ready byte streams on the bus side, FIFO-buffered in both directions.
module uart_flow_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int RTS_THRESH   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 cts,
  output logic                 tx,
  output logic                 rts,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  output logic                 rx_frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] RTS_LVL = CW'(RTS_THRESH);
  localparam logic [TW-1:0] T_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_MID   = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  // Pin synchronisers preset to the idle-high / clear-to-send level
  logic cts_m, cts_s, rx_m, rx_s, rx_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cts_m   <= 1'b1;
      cts_s   <= 1'b1;
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      cts_m   <= cts;
      cts_s   <= cts_m;
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]        tx_wp, tx_rp;
  logic [CW-1:0]        tx_cnt;
  logic                 tx_push, tx_pop;
  state_t               tx_state;

  assign tx_ready = (tx_cnt != FULL);
  assign tx_push  = tx_valid && tx_ready;
  assign tx_pop   = (tx_state == S_IDLE) && (tx_cnt != '0) && cts_s;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= tx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  logic [TW-1:0]        tx_tick;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx       <= 1'b1;
      tx_tick  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_pop) begin
            tx_shift <= tx_mem[tx_rp];
            tx       <= 1'b0;
            tx_tick  <= '0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_tick == T_LAST) begin
            tx       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_tick  <= '0;
            tx_bit   <= '0;
            tx_state <= S_DATA;
          end else begin
            tx_tick <= tx_tick + TW'(1);
          end
        end
        S_DATA: begin
          if (tx_tick == T_LAST) begin
            tx_tick <= '0;
            if (tx_bit == B_LAST) begin
              tx       <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + BW'(1);
            end
          end else begin
            tx_tick <= tx_tick + TW'(1);
          end
        end
        S_STOP: begin
          // Returning through IDLE gives the single idle-high cycle between frames
          if (tx_tick == T_LAST) tx_state <= S_IDLE;
          else                   tx_tick  <= tx_tick + TW'(1);
        end
        default: begin
          tx       <= 1'b1;
          tx_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------- RX FSM ----------------
  state_t               rx_state;
  logic [TW-1:0]        rx_tick;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic [CW-1:0]        rx_cnt;
  logic                 rx_push_req, rx_push_ok, rx_pop;

  assign rx_push_req = (rx_state == S_STOP) && (rx_tick == T_LAST) && rx_s;
  assign rx_pop      = rx_valid && rx_ready;
  assign rx_push_ok  = rx_push_req && ((rx_cnt != FULL) || rx_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state     <= S_IDLE;
      rx_tick      <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_overrun   <= rx_push_req && !rx_push_ok;
      rx_frame_err <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_tick  <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_tick == T_MID) begin
            rx_tick  <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            rx_tick <= rx_tick + TW'(1);
          end
        end
        S_DATA: begin
          if (rx_tick == T_LAST) begin
            rx_tick  <= '0;
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == B_LAST) rx_state <= S_STOP;
            else                  rx_bit   <= rx_bit + BW'(1);
          end else begin
            rx_tick <= rx_tick + TW'(1);
          end
        end
        S_STOP: begin
          if (rx_tick == T_LAST) begin
            if (rx_s) begin
              rx_state <= S_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              rx_state     <= S_BREAK;
            end
          end else begin
            rx_tick <= rx_tick + TW'(1);
          end
        end
        S_BREAK: begin
          if (rx_s) rx_state <= S_IDLE;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]        rx_wp, rx_rp;

  assign rx_valid = (rx_cnt != '0);
  assign rx_data  = rx_valid ? rx_mem[rx_rp] : '0;

  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_mem[rx_wp] <= rx_shift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      rts    <= 1'b1;
    end else begin
      if (rx_push_ok) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)     rx_rp <= rx_rp + AW'(1);
      case ({rx_push_ok, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
      rts <= (rx_cnt < RTS_LVL);
    end
  end

endmodule

// File: tb/tb_uart_flow_ctrl.sv
// tb/tb_uart_flow_ctrl.sv - directed self-checking bench for uart_flow_ctrl
module tb_uart_flow_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_drv, loop_en, rx_pin;
  logic       cts;
  logic       tx, rts;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       rx_overrun, rx_frame_err;

  int n_eval = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rx_pin = loop_en ? tx : rx_drv;

  uart_flow_ctrl #(
    .DATA_BITS(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .RTS_THRESH(3)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx_pin), .cts(cts), .tx(tx), .rts(rts),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    @(negedge clk);
    chk("tx_ready before push", {31'b0, tx_ready}, 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Checks 40 consecutive cycles of a frame; the first sample is the current negedge.
  task automatic check_bits(input logic [7:0] b, input string tag);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("%s cyc%0d", tag, i), {31'b0, tx}, {31'b0, f[i/4]});
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int lows;
    reset = 1'b1; rx_drv = 1'b1; loop_en = 1'b0; cts = 1'b1;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset tx", {31'b0, tx}, 32'd1);
    chk("reset rts", {31'b0, rts}, 32'd1);
    chk("reset tx_ready", {31'b0, tx_ready}, 32'd1);
    chk("reset rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("reset rx_data", {24'b0, rx_data}, 32'd0);
    chk("reset rx_overrun", {31'b0, rx_overrun}, 32'd0);
    chk("reset rx_frame_err", {31'b0, rx_frame_err}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single frame 0xA5, start bit one cycle after the push is seen
    push_tx(8'hA5);
    chk("t1 idle after push", {31'b0, tx}, 32'd1);
    @(negedge clk);
    check_bits(8'hA5, "t1 A5");

    // 2: cts low holds frames back, then two back-to-back frames
    @(negedge clk);
    cts = 1'b0;
    repeat (4) @(negedge clk);
    push_tx(8'h3C);
    push_tx(8'h5A);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t2 tx held by cts", {31'b0, tx}, 32'd1);
    end
    cts = 1'b1;
    repeat (3) @(negedge clk);
    check_bits(8'h3C, "t2 3C");
    @(negedge clk);
    chk("t2 idle gap", {31'b0, tx}, 32'd1);
    @(negedge clk);
    check_bits(8'h5A, "t2 5A");

    // 3: loopback fill of the RX FIFO, rts throttle and overrun
    @(negedge clk);
    loop_en = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    push_tx(8'h01);
    push_tx(8'h02);
    push_tx(8'h03);
    push_tx(8'h04);
    push_tx(8'h05);
    // t counts negedges from the first start bit of 0x01 on the line
    t = 7;
    while (t < 207) begin
      @(negedge clk);
      t++;
      if (t == 40)  chk("t3 rx_valid before 1st push", {31'b0, rx_valid}, 32'd0);
      if (t == 41)  chk("t3 rx_valid after 1st push", {31'b0, rx_valid}, 32'd1);
      if (t == 41)  chk("t3 rx_data head", {24'b0, rx_data}, 32'h01);
      if (t == 82)  chk("t3 rts at 2", {31'b0, rts}, 32'd1);
      if (t == 123) chk("t3 rts same cycle as 3rd push", {31'b0, rts}, 32'd1);
      if (t == 124) chk("t3 rts one cycle after 3rd push", {31'b0, rts}, 32'd0);
      if (t == 204) chk("t3 overrun before", {31'b0, rx_overrun}, 32'd0);
      if (t == 205) chk("t3 overrun pulse", {31'b0, rx_overrun}, 32'd1);
      if (t == 206) chk("t3 overrun after", {31'b0, rx_overrun}, 32'd0);
    end
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t3 rx_valid %0d", k), {31'b0, rx_valid}, 32'd1);
      chk($sformatf("t3 rx_data %0d", k), {24'b0, rx_data}, k);
      rx_ready = 1'b1;
      @(negedge clk);
    end
    rx_ready = 1'b0;
    loop_en = 1'b0;
    chk("t3 rx fifo drained", {31'b0, rx_valid}, 32'd0);
    chk("t3 rts restored", {31'b0, rts}, 32'd1);

    // 4: framing error, long break, then a clean frame
    repeat (4) @(negedge clk);
    send_rx(8'h96, 1'b0);
    chk("t4 frame_err before", {31'b0, rx_frame_err}, 32'd0);
    @(negedge clk);
    chk("t4 frame_err pulse", {31'b0, rx_frame_err}, 32'd1);
    @(negedge clk);
    chk("t4 frame_err after", {31'b0, rx_frame_err}, 32'd0);
    chk("t4 no push on bad stop", {31'b0, rx_valid}, 32'd0);
    repeat (14) @(negedge clk);
    rx_drv = 1'b1;
    repeat (4) @(negedge clk);
    send_rx(8'h11, 1'b1);
    chk("t4 11 not yet pushed", {31'b0, rx_valid}, 32'd0);
    @(negedge clk);
    chk("t4 11 rx_valid", {31'b0, rx_valid}, 32'd1);
    chk("t4 11 rx_data", {24'b0, rx_data}, 32'h11);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("t4 popped", {31'b0, rx_valid}, 32'd0);

    // 5: one-cycle glitch is rejected, receiver still ready afterwards
    repeat (4) @(negedge clk);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t5 no frame_err on glitch", {31'b0, rx_frame_err}, 32'd0);
    end
    chk("t5 no push on glitch", {31'b0, rx_valid}, 32'd0);
    send_rx(8'hC3, 1'b1);
    @(negedge clk);
    chk("t5 C3 rx_valid", {31'b0, rx_valid}, 32'd1);
    chk("t5 C3 rx_data", {24'b0, rx_data}, 32'hC3);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;

    // 6: reset in the middle of a frame with another byte queued
    repeat (4) @(negedge clk);
    push_tx(8'h00);
    push_tx(8'h77);
    repeat (15) @(negedge clk);
    chk("t6 tx low mid-frame", {31'b0, tx}, 32'd0);
    reset = 1'b1;
    #1;
    chk("t6 tx async reset", {31'b0, tx}, 32'd1);
    chk("t6 tx_ready async reset", {31'b0, tx_ready}, 32'd1);
    chk("t6 rts async reset", {31'b0, rts}, 32'd1);
    chk("t6 rx_valid async reset", {31'b0, rx_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("t6 queued byte flushed", lows, 32'd0);
    chk("t6 tx_ready after reset", {31'b0, tx_ready}, 32'd1);
    chk("t6 rx_valid after reset", {31'b0, rx_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
